// File: rtl/mux4t1_4.sv
// mux4t1_4: 4-to-1 bus selector with a combinational output,
// a registered copy, the select behind that copy and a change strobe.
module mux4t1_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] o_q,
  output logic [1:0]       s_q,
  output logic             chg
);

  logic [WIDTH-1:0] w_o;
  logic [WIDTH-1:0] r_o_q;
  logic [1:0]       r_s_q;
  logic             r_chg;

  // Select one input; an unknown select yields X in simulation
  always_comb begin
    w_o = '0;
    case (s)
      2'd0:    w_o = I0;
      2'd1:    w_o = I1;
      2'd2:    w_o = I2;
      2'd3:    w_o = I3;
      default: w_o = 'x;
    endcase
  end

  // Capture the live output and flag when the captured value moves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_o_q <= '0;
      r_s_q <= '0;
      r_chg <= 1'b0;
    end else begin
      r_o_q <= w_o;
      r_s_q <= s;
      r_chg <= (w_o != r_o_q);
    end
  end

  assign o   = w_o;
  assign o_q = r_o_q;
  assign s_q = r_s_q;
  assign chg = r_chg;

endmodule

// File: tb/tb_mux4t1_4.sv
// tb_mux4t1_4: directed vectors for mux4t1_4,
// plus a seeded sweep against a table-lookup reference.
module tb_mux4t1_4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] s;
  logic [3:0] I0, I1, I2, I3;
  logic [3:0] o, o_q;
  logic [1:0] s_q;
  logic       chg;

  int total = 0;
  int bad   = 0;
  logic [3:0] prev_q;

  mux4t1_4 #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .s   (s),
    .I0  (I0),
    .I1  (I1),
    .I2  (I2),
    .I3  (I3),
    .o   (o),
    .o_q (o_q),
    .s_q (s_q),
    .chg (chg)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; returns just after the next negedge.
  task automatic vec(input string tag,
                     input logic [1:0] sv,
                     input logic [3:0] a, b, c, d,
                     input logic [3:0] eo);
    s = sv; I0 = a; I1 = b; I2 = c; I3 = d;
    #1;
    chk({tag, ".o"}, 32'(o), 32'(eo));
    @(posedge clk); #1;
    chk({tag, ".o_q"}, 32'(o_q), 32'(eo));
    chk({tag, ".s_q"}, 32'(s_q), 32'(sv));
    chk({tag, ".chg"}, 32'(chg), 32'(eo != prev_q));
    prev_q = eo;
    @(negedge clk);
  endtask

  // Select-indexed lookup used only by the seeded sweep
  function automatic logic [3:0] ref_mux(input logic [1:0] sv,
                                         input logic [3:0] a, b, c, d);
    logic [3:0] tbl [4];
    tbl[0] = a; tbl[1] = b; tbl[2] = c; tbl[3] = d;
    return tbl[sv];
  endfunction

  initial begin
    rst = 1'b0;
    s = 2'd0; I0 = 4'h0; I1 = 4'h0; I2 = 4'h0; I3 = 4'h0;
    #2 rst = 1'b1;
    #1;
    chk("rst.o_q", 32'(o_q), 32'h0);
    chk("rst.s_q", 32'(s_q), 32'h0);
    chk("rst.chg", 32'(chg), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    prev_q = 4'h0;

    // 1: identity sweep
    vec("t1s0", 2'd0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h0);
    vec("t1s1", 2'd1, 4'h0, 4'h1, 4'h2, 4'h3, 4'h1);
    vec("t1s2", 2'd2, 4'h0, 4'h1, 4'h2, 4'h3, 4'h2);
    vec("t1s3", 2'd3, 4'h0, 4'h1, 4'h2, 4'h3, 4'h3);

    // 2: alternating pattern, chg on every 5<->A move
    vec("t2s0", 2'd0, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5);
    vec("t2s1", 2'd1, 4'h5, 4'hA, 4'h5, 4'hA, 4'hA);
    vec("t2s2", 2'd2, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5);
    vec("t2s3", 2'd3, 4'h5, 4'hA, 4'h5, 4'hA, 4'hA);

    // 3: s=2 fixed, unselected inputs churn
    vec("t3a", 2'd2, 4'hF, 4'h0, 4'h6, 4'h9, 4'h6);
    vec("t3b", 2'd2, 4'h1, 4'hE, 4'h6, 4'h2, 4'h6);
    vec("t3c", 2'd2, 4'hC, 4'h3, 4'h6, 4'hD, 4'h6);

    // select moves but data equal: no strobe
    vec("same0", 2'd0, 4'h7, 4'h7, 4'h1, 4'h2, 4'h7);
    vec("same1", 2'd1, 4'h7, 4'h7, 4'h1, 4'h2, 4'h7);

    // 4: async reset mid-operation with o=A
    vec("t4a", 2'd1, 4'h0, 4'hA, 4'h0, 4'h0, 4'hA);
    #2 rst = 1'b1;
    #1;
    chk("t4.o_q", 32'(o_q), 32'h0);
    chk("t4.s_q", 32'(s_q), 32'h0);
    chk("t4.chg", 32'(chg), 32'h0);
    chk("t4.o",   32'(o),   32'hA);
    @(posedge clk); #1;
    chk("t4h.o_q", 32'(o_q), 32'h0);
    chk("t4h.o",   32'(o),   32'hA);
    @(negedge clk);
    rst = 1'b0;
    prev_q = 4'h0;

    // 5: first edges after release
    vec("t5a", 2'd1, 4'h0, 4'hA, 4'h0, 4'h0, 4'hA);
    vec("t5b", 2'd1, 4'h0, 4'hA, 4'h0, 4'h0, 4'hA);

    // 6: seeded sweep against the lookup reference
    for (int i = 0; i < 200; i++) begin
      logic [1:0] rs;
      logic [3:0] ra, rb, rc, rd;
      rs = 2'($urandom_range(0, 3));
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 4'($urandom_range(0, 15));
      rd = 4'($urandom_range(0, 15));
      vec("t6", rs, ra, rb, rc, rd, ref_mux(rs, ra, rb, rc, rd));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
